// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between store address/data generation and
// data memory. Captures one store per cycle and drains entries in program
// order whenever memory accepts the head entry.
//
// Optional feature macro: STORE_BUFFER_FWD_EN
//   defined   -> ld_addr is compared against every valid entry; ld_hit/ld_data
//                report the youngest matching store.
//   undefined -> ld_addr is ignored, ld_hit = 0, ld_data = 0, no comparators.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         write_enable,
  output logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            write_data,
  input  logic                         mem_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hit,
  output logic [DATA_W-1:0]            ld_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic enq;
  logic deq;

  // Status flags and handshakes derived purely from the occupancy count.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign in_ready     = !full;
  assign write_enable = !empty;
  assign count        = count_q;
  assign enq          = in_valid && in_ready;
  assign deq          = write_enable && mem_ready;

  // Head entry is presented to memory; outputs are forced to 0 when empty so
  // stale storage never leaks onto the memory bus.
  assign address    = empty ? '0 : addr_mem[rd_ptr_q];
  assign write_data = empty ? '0 : data_mem[rd_ptr_q];

  // Next-state for pointers and occupancy count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards all buffered entries at once.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write on enqueue.
  // NOTE: the storage array has no reset; validity comes only from rd_ptr and
  // count, so clearing it would cost flops for no behavioural gain.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= in_addr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  // Forwarding lookup: scan valid entries oldest to youngest so the last
  // match seen (the youngest) wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_mem[idx];
      end
    end
  end
`else
  // Forwarding disabled: lookup outputs tied off, load address unused.
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hit         = 1'b0;
  assign ld_data        = '0;
`endif

endmodule
